// File: rtl/vixen_l2_responder.sv
// vixen_l2_responder: fixed-latency L2 stand-in serving icache/dcache line fills.
// Define VIXEN_L2RESP_PERF_EN to enable the completion counters.
module vixen_l2_responder #(
  parameter int NUM_LINES = 16,
  parameter int LATENCY   = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         ic_req,
  input  logic [63:0]  ic_addr,
  output logic [511:0] ic_data,
  output logic         ic_ack,
  input  logic         dc_req,
  input  logic [63:0]  dc_addr,
  input  logic         dc_we,
  input  logic [511:0] dc_wdata,
  output logic [511:0] dc_rdata,
  output logic         dc_ack,
  output logic         busy,
  output logic [31:0]  perf_ic_reqs,
  output logic [31:0]  perf_dc_reqs
);
  localparam int IW = $clog2(NUM_LINES);
  localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  typedef enum logic [1:0] {IDLE, WAIT, ACK} state_t;

  state_t          state;
  logic [CW-1:0]   cnt;
  logic            last_dc;
  logic            g_dc;
  logic            g_we;
  logic [IW-1:0]   g_idx;
  logic [511:0]    g_wdata;
  logic [511:0]    store [NUM_LINES];

  logic            any_req;
  logic            pick_dc;
  logic            fire;
  logic            f_dc;
  logic            f_we;
  logic [IW-1:0]   f_idx;
  logic [511:0]    f_wdata;
  logic [511:0]    f_line;

  // With LATENCY==1 the ack is produced straight from the grant cycle inputs.
  always_comb begin
    any_req = ic_req | dc_req;
    pick_dc = dc_req & (~ic_req | ~last_dc);
    if (state == IDLE) begin
      fire    = any_req & (LATENCY == 1);
      f_dc    = pick_dc;
      f_we    = pick_dc & dc_we;
      f_idx   = pick_dc ? dc_addr[6 +: IW] : ic_addr[6 +: IW];
      f_wdata = dc_wdata;
    end else begin
      fire    = (state == WAIT) & (cnt == CW'(1));
      f_dc    = g_dc;
      f_we    = g_we;
      f_idx   = g_idx;
      f_wdata = g_wdata;
    end
    f_line = store[f_idx];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      cnt      <= '0;
      last_dc  <= 1'b1;
      g_dc     <= 1'b0;
      g_we     <= 1'b0;
      g_idx    <= '0;
      g_wdata  <= '0;
      busy     <= 1'b0;
      ic_ack   <= 1'b0;
      dc_ack   <= 1'b0;
      ic_data  <= '0;
      dc_rdata <= '0;
      for (int i = 0; i < NUM_LINES; i++) store[i] <= '0;
    end else begin
      ic_ack <= 1'b0;
      dc_ack <= 1'b0;
      unique case (state)
        IDLE: begin
          if (any_req) begin
            state   <= (LATENCY == 1) ? ACK : WAIT;
            cnt     <= CW'(LATENCY - 1);
            busy    <= 1'b1;
            last_dc <= pick_dc;
            g_dc    <= pick_dc;
            g_we    <= pick_dc & dc_we;
            g_idx   <= f_idx;
            g_wdata <= dc_wdata;
          end
        end
        WAIT: begin
          if (fire) state <= ACK;
          else      cnt   <= cnt - CW'(1);
        end
        ACK: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
      if (fire) begin
        if (f_dc) begin
          dc_ack   <= 1'b1;
          dc_rdata <= f_we ? f_wdata : f_line;
          if (f_we) store[f_idx] <= f_wdata;
        end else begin
          ic_ack  <= 1'b1;
          ic_data <= f_line;
        end
      end
    end
  end

`ifdef VIXEN_L2RESP_PERF_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      perf_ic_reqs <= '0;
      perf_dc_reqs <= '0;
    end else if (fire) begin
      if (f_dc && perf_dc_reqs != '1) perf_dc_reqs <= perf_dc_reqs + 32'd1;
      if (!f_dc && perf_ic_reqs != '1) perf_ic_reqs <= perf_ic_reqs + 32'd1;
    end
  end
`else
  assign perf_ic_reqs = '0;
  assign perf_dc_reqs = '0;
`endif

  logic unused;
  assign unused = ^{ic_addr[5:0], ic_addr[63:6+IW],
                    dc_addr[5:0], dc_addr[63:6+IW]};

endmodule

// File: tb/tb_vixen_l2_responder.sv
// Bench for vixen_l2_responder: vector table, corner sequences, random vs model.
// Honours VIXEN_L2RESP_PERF_EN for the expected counter values.
module tb_vixen_l2_responder;
  localparam int L = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst_n;
  logic         ic_req, dc_req, dc_we;
  logic [63:0]  ic_addr, dc_addr;
  logic [511:0] dc_wdata;
  logic [511:0] ic_data, dc_rdata;
  logic         ic_ack, dc_ack, busy;
  logic [31:0]  perf_ic, perf_dc;

  logic         q_req;
  logic [511:0] q_data, q_rdata;
  logic         q_ack, q_dack, q_busy;
  logic [31:0]  q_pic, q_pdc;

  vixen_l2_responder #(.NUM_LINES(16), .LATENCY(L)) dut (
    .clk(clk), .rst_n(rst_n),
    .ic_req(ic_req), .ic_addr(ic_addr), .ic_data(ic_data), .ic_ack(ic_ack),
    .dc_req(dc_req), .dc_addr(dc_addr), .dc_we(dc_we), .dc_wdata(dc_wdata),
    .dc_rdata(dc_rdata), .dc_ack(dc_ack), .busy(busy),
    .perf_ic_reqs(perf_ic), .perf_dc_reqs(perf_dc)
  );

  vixen_l2_responder #(.NUM_LINES(16), .LATENCY(1)) dut1 (
    .clk(clk), .rst_n(rst_n),
    .ic_req(q_req), .ic_addr(64'h80), .ic_data(q_data), .ic_ack(q_ack),
    .dc_req(1'b0), .dc_addr(64'h0), .dc_we(1'b0), .dc_wdata(512'h0),
    .dc_rdata(q_rdata), .dc_ack(q_dack), .busy(q_busy),
    .perf_ic_reqs(q_pic), .perf_dc_reqs(q_pdc)
  );

  typedef struct {
    bit           dc;
    bit           we;
    logic [63:0]  addr;
    logic [511:0] wd;
    logic [511:0] exp;
  } vec_t;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [511:0] act,
                     input logic [511:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; ic_req = 1'b0; dc_req = 1'b0; dc_we = 1'b0; q_req = 1'b0;
    ic_addr = '0; dc_addr = '0; dc_wdata = '0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic txn(input vec_t v, output logic [511:0] rd, output int lat);
    bit got;
    got = 1'b0; lat = 0; rd = '0;
    if (v.dc) begin
      dc_req = 1'b1; dc_we = v.we; dc_addr = v.addr; dc_wdata = v.wd;
    end else begin
      ic_req = 1'b1; ic_addr = v.addr;
    end
    for (int c = 1; c <= 20 && !got; c++) begin
      tick();
      if (v.dc ? dc_ack : ic_ack) begin
        got = 1'b1; lat = c;
        rd = v.dc ? dc_rdata : ic_data;
        ic_req = 1'b0; dc_req = 1'b0;
      end
    end
    if (!got) begin
      n_cmp++; n_bad++;
      $display("FAIL txn_timeout: got no ack want ack within 20 cycles");
      ic_req = 1'b0; dc_req = 1'b0;
    end
    tick();
    chk("ack_one_cycle", {ic_ack, dc_ack}, 2'b00);
  endtask

  vec_t         tbl [6];
  logic [511:0] rd;
  int           lat;
  logic [511:0] mm [16];
  bit           gv, gdc, ldc, ic_out, dc_out, ea_ic, ea_dc, eb;
  int           gc, free_at, nic, ndc;
  logic [511:0] gd, eic, edc;
  logic [3:0]   idx;

  initial begin
    tbl[0] = '{1'b1, 1'b1, 64'h1C0, {64{8'hA5}}, {64{8'hA5}}};
    tbl[1] = '{1'b0, 1'b0, 64'h1C0, 512'h0, {64{8'hA5}}};
    tbl[2] = '{1'b1, 1'b1, 64'h400, 512'h1234, 512'h1234};
    tbl[3] = '{1'b1, 1'b0, 64'h0, 512'h0, 512'h1234};
    tbl[4] = '{1'b0, 1'b0, 64'h440, 512'h0, 512'h0};
    tbl[5] = '{1'b1, 1'b0, 64'hFFFF_0000_0000_01FF, 512'h0, {64{8'hA5}}};

    do_reset();
    chk("rst_outputs", {ic_ack, dc_ack, busy, perf_ic, perf_dc}, '0);
    chk("rst_ic_data", ic_data, '0);
    chk("rst_dc_rdata", dc_rdata, '0);

    // read after reset
    ic_addr = 64'h0; ic_req = 1'b1;
    for (int c = 1; c <= 6; c++) begin
      tick();
      chk($sformatf("rar_ack_c%0d", c), ic_ack, c == 4);
      chk($sformatf("rar_busy_c%0d", c), busy, c <= 4);
      if (c == 4) begin
        chk("rar_data", ic_data, '0);
        ic_req = 1'b0;
      end
    end

    for (int i = 0; i < 6; i++) begin
      txn(tbl[i], rd, lat);
      chk($sformatf("vec%0d_data", i), rd, tbl[i].exp);
      chk($sformatf("vec%0d_lat", i), lat, L);
    end

    // simultaneous requests held from reset
    do_reset();
    ic_req = 1'b1; dc_req = 1'b1; dc_we = 1'b0;
    for (int c = 1; c <= 15; c++) begin
      tick();
      chk($sformatf("sim_ic_c%0d", c), ic_ack, c == 4 || c == 14);
      chk($sformatf("sim_dc_c%0d", c), dc_ack, c == 9);
      chk($sformatf("sim_excl_c%0d", c), ic_ack & dc_ack, 1'b0);
    end

    // minimum latency instance, back-to-back icache
    do_reset();
    q_req = 1'b1;
    for (int c = 1; c <= 6; c++) begin
      tick();
      chk($sformatf("min_ack_c%0d", c), q_ack, c == 1 || c == 3 || c == 5);
      if (c == 5) q_req = 1'b0;
    end
`ifdef VIXEN_L2RESP_PERF_EN
    chk("min_perf", q_pic, 32'd3);
`else
    chk("min_perf", q_pic, 32'd0);
`endif

    // reset in the middle of a write
    do_reset();
    dc_req = 1'b1; dc_we = 1'b1; dc_addr = 64'h40; dc_wdata = '1;
    tick();
    tick();
    rst_n = 1'b0; dc_req = 1'b0;
    tick();
    chk("mid_busy", busy, 1'b0);
    chk("mid_ack", dc_ack, 1'b0);
    rst_n = 1'b1;
    for (int c = 4; c <= 8; c++) begin
      tick();
      chk($sformatf("mid_noack_c%0d", c), {dc_ack, busy}, 2'b00);
    end
    txn('{1'b1, 1'b0, 64'h40, 512'h0, 512'h0}, rd, lat);
    chk("mid_read", rd, '0);

    // randomized traffic against a transaction-level model
    do_reset();
    for (int i = 0; i < 16; i++) mm[i] = '0;
    gv = 0; gdc = 0; ldc = 1; ic_out = 0; dc_out = 0;
    gc = 0; free_at = 0; nic = 0; ndc = 0;
    gd = '0; eic = '0; edc = '0;
    for (int k = 0; k < 700; k++) begin
      ea_ic = 0; ea_dc = 0;
      if (k > 0) begin
        ea_ic = gv && !gdc && k == gc + L;
        ea_dc = gv && gdc && k == gc + L;
        eb = gv && k > gc && k <= gc + L;
        if (ea_ic) begin eic = gd; nic++; ic_out = 0; gv = 0; end
        if (ea_dc) begin edc = gd; ndc++; dc_out = 0; gv = 0; end
        chk("rnd_ic_ack", ic_ack, ea_ic);
        chk("rnd_dc_ack", dc_ack, ea_dc);
        chk("rnd_busy", busy, eb);
        chk("rnd_ic_data", ic_data, eic);
        chk("rnd_dc_rdata", dc_rdata, edc);
`ifdef VIXEN_L2RESP_PERF_EN
        chk("rnd_perf", {perf_ic, perf_dc}, {nic[31:0], ndc[31:0]});
`else
        chk("rnd_perf", {perf_ic, perf_dc}, 64'h0);
`endif
      end
      if (ic_out) begin
        if ($urandom_range(0, 3) == 0) begin
          ic_req = 1'b0; ic_addr = {$urandom, $urandom};
        end
      end else if (ea_ic || !ic_req) begin
        ic_req = $urandom_range(0, 1) == 1;
        ic_addr = {$urandom, $urandom};
      end
      if (dc_out) begin
        if ($urandom_range(0, 2) == 0) begin
          dc_req = $urandom_range(0, 1) == 1;
          dc_we = $urandom_range(0, 1) == 1;
          dc_addr = {$urandom, $urandom};
          for (int j = 0; j < 16; j++) dc_wdata[j*32 +: 32] = $urandom;
        end
      end else if (ea_dc || !dc_req) begin
        dc_req = $urandom_range(0, 1) == 1;
        dc_we = $urandom_range(0, 1) == 1;
        dc_addr = {$urandom, $urandom};
        for (int j = 0; j < 16; j++) dc_wdata[j*32 +: 32] = $urandom;
      end
      if (!gv && k >= free_at && (ic_req || dc_req)) begin
        gdc = dc_req && (!ic_req || !ldc);
        idx = gdc ? dc_addr[9:6] : ic_addr[9:6];
        if (gdc && dc_we) begin
          mm[idx] = dc_wdata;
          gd = dc_wdata;
        end else begin
          gd = mm[idx];
        end
        gv = 1; gc = k; free_at = k + L + 1; ldc = gdc;
        if (gdc) dc_out = 1;
        else     ic_out = 1;
      end
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/vixen_l2_responder.md
# vixen_l2_responder

L2-side responder for the L1 cache miss/fill interface: the target end of the `l2_req`/`l2_addr`/`l2_wdata`/`l2_we`/`l2_ack` handshake that the L1 instruction and data caches initiate. It arbitrates between one icache port and one dcache port and services line reads and writes from a small register-based line store after a fixed, parameterised latency. It stands in for the L2 during core bring-up and SoC integration, with cycle-deterministic behaviour.

## Interface
- `NUM_LINES`, 16, line-store depth; power of two, at least 2.
- `LATENCY`, 4, cycles from grant to ack; at least 1.
- `clk`  in  1  system clock; all logic on the rising edge.
- `rst_n`  in  1  synchronous, active-low reset.
- `ic_req`  in  1  icache request; level, held until `ic_ack`.
- `ic_addr`  in  64  icache line address; bits [5:0] ignored.
- `ic_data`  out  512  icache fill line; valid in the `ic_ack` cycle, held until the next icache ack.
- `ic_ack`  out  1  one-cycle completion pulse.
- `dc_req`  in  1  dcache request; level, held until `dc_ack`.
- `dc_addr`  in  64  dcache line address; bits [5:0] ignored.
- `dc_we`  in  1  1 = line write, 0 = line read.
- `dc_wdata`  in  512  write line.
- `dc_rdata`  out  512  read line, or the echoed write line; valid in the `dc_ack` cycle, then held.
- `dc_ack`  out  1  one-cycle completion pulse.
- `busy`  out  1  high while a transaction is in flight.
- `perf_ic_reqs`  out  32  completed icache transactions.
- `perf_dc_reqs`  out  32  completed dcache transactions.

## Operation
- **Line index:** `addr[6 +: $clog2(NUM_LINES)]`. Higher address bits alias, so there are no tag checks.
- **Line store:** `NUM_LINES` x 512 bits, cleared to zero on reset.
- **State machine:** IDLE, WAIT, ACK.
- **IDLE:**
  - If any request is high, grant one port.
  - Capture port, index, `dc_we` and `dc_wdata`, and load the counter with `LATENCY-1`.
  - Go to ACK if `LATENCY==1`, otherwise go to WAIT.
- **WAIT:** decrement the counter; go to ACK when it reaches 1.
- **ACK:**
  - Pulse the granted port's ack for exactly one cycle.
  - On a read, the port's data output takes `store[index]`.
  - On a write, `store[index]` takes the captured wdata and `dc_rdata` takes the same value.
  - Return to IDLE.
- **Arbitration:** round-robin.
  - On simultaneous requests, grant the port not granted last.
  - The last-grant pointer resets to dcache, so icache wins the first tie.
  - A lone requester is always granted.
- **Requests held across ack:** a request still high in the cycle after its ack is a new request.
- **Captured transactions:** a request dropped after grant still completes and acks. Address, wdata and we changes after grant are ignored.
- **Ordering:** a write is visible to any transaction granted after its ack cycle. Because service is strictly serial, there are no hazards.
- **Reset mid-operation:** abort to IDLE with no ack and no store write.
- **Output reset values:** all outputs reset to 0 (acks, `busy`, data outputs, counters).

## Timing
- The grant cycle (cycle 0) is an IDLE cycle in which a request is sampled high.
- The ack is asserted in cycle `LATENCY`, and `busy` is high in cycles 1..`LATENCY`.
- The next grant comes at the earliest in cycle `LATENCY+1`. Throughput is one transaction per `LATENCY+1` cycles.
- All outputs are registered; there is no combinational path from input to output.
- Icache and dcache acks are never high in the same cycle.

## Configuration
- **With `VIXEN_L2RESP_PERF_EN` defined:**
  - `perf_ic_reqs` and `perf_dc_reqs` increment in the ack cycle of their port.
  - Both counters saturate at 0xFFFF_FFFF and reset to 0.
- **Without the macro:** the counter logic is absent and both perf outputs are tied to 0.

## Test plan
- **Read after reset** (defaults): reset, then `ic_req`=1 with `ic_addr`=0x0 in cycle 0.
  - `ic_ack` pulses in cycle 4 only and `ic_data`=0.
  - `busy` is high in cycles 1-4.
- **Write then read:** dcache write of 0xA5…A5 to 0x1C0, then icache read of 0x1C0.
  - `dc_ack` returns `dc_rdata`=0xA5…A5.
  - `ic_data`=0xA5…A5.
- **Alias wrap:** write 0x1234 (zero-extended) to 0x400, then dcache read of 0x0.
  - The read returns 0x1234, because index 0 aliases with `NUM_LINES`=16.
- **Simultaneous requests:** `ic_req` and `dc_req` both held high from reset.
  - Acks alternate icache (cycle 4), dcache (cycle 9), icache (cycle 14).
  - No two acks share a cycle.
- **Minimum latency:** `LATENCY`=1 with back-to-back icache requests.
  - Acks arrive in cycles 1, 3, 5.
  - With `VIXEN_L2RESP_PERF_EN`, `perf_ic_reqs`=3. Without it, the counter stays 0.
- **Reset mid-operation:** dcache write to 0x40 with `rst_n` low in cycle 2.
  - No `dc_ack`; `busy` is 0 from the cycle after the reset edge.
  - A later read of 0x40 returns 0.
